// File: rtl/toy_mem_responder_if.sv
// Bundle of core-facing fetch/data ports, backdoor load port and host-visible console/exit signals.
interface toy_mem_responder_if #(
  parameter int unsigned AW = 10
);
  logic          IREQ;
  logic [29:0]   IADDR;
  logic [31:0]   INSTR;
  logic          DREQ;
  logic [1:0]    DRW;
  logic [29:0]   DADDR;
  logic [31:0]   DWDATA;
  logic [31:0]   DRDATA;
  logic          LD_EN;
  logic [AW-1:0] LD_ADDR;
  logic [31:0]   LD_DATA;
  logic          CON_VALID;
  logic [7:0]    CON_DATA;
  logic          CON_POP;
  logic          TOHOST_VALID;
  logic [31:0]   TOHOST_DATA;

  modport master (
    output IREQ, IADDR, DREQ, DRW, DADDR, DWDATA, LD_EN, LD_ADDR, LD_DATA, CON_POP,
    input  INSTR, DRDATA, CON_VALID, CON_DATA, TOHOST_VALID, TOHOST_DATA
  );

  modport slave (
    input  IREQ, IADDR, DREQ, DRW, DADDR, DWDATA, LD_EN, LD_ADDR, LD_DATA, CON_POP,
    output INSTR, DRDATA, CON_VALID, CON_DATA, TOHOST_VALID, TOHOST_DATA
  );
endinterface

// File: rtl/toy_mem_responder.sv
// Unified word RAM plus MMIO (cycle counter, TOHOST, console FIFO) answering the RISC_TOY core.
module toy_mem_responder #(
  parameter int unsigned AW     = 10,
  parameter int unsigned CON_AW = 3
) (
  input logic               CLK,
  input logic               RSTN,
  toy_mem_responder_if.slave bus
);
  localparam int unsigned   CntW     = CON_AW + 1;
  localparam logic [CntW-1:0] ConDepth = CntW'(2 ** CON_AW);

  logic [31:0] mem     [2**AW];
  logic [7:0]  con_mem [2**CON_AW];

  logic [31:0]       drdata_q, cycle_q, tohost_data_q;
  logic              tohost_valid_q;
  logic              ovf_q, ovf_d;
  logic [CON_AW-1:0] con_wptr_q, con_wptr_d, con_rptr_q, con_rptr_d;
  logic [CntW-1:0]   con_cnt_q, con_cnt_d;

  logic          is_mmio, rd, wr, ram_we, tohost_we;
  logic          con_push, con_pop, con_full, con_accept;
  logic [AW-1:0] d_idx;
  logic [31:0]   rd_word;
  logic          unused_addr_bits;

  assign is_mmio   = bus.DADDR[29:28] == 2'b11;
  assign d_idx     = bus.DADDR[AW-1:0];
  assign rd        = bus.DREQ && (bus.DRW == 2'b00);
  assign wr        = bus.DREQ && (bus.DRW == 2'b01);
  assign ram_we    = wr && !is_mmio;
  assign tohost_we = wr && is_mmio && (bus.DADDR[1:0] == 2'd1);
  assign con_push  = wr && is_mmio && (bus.DADDR[1:0] == 2'd2);
  assign con_pop   = bus.CON_POP && (con_cnt_q != '0);
  assign con_full  = con_cnt_q == ConDepth;
  // A push into a full FIFO only lands if the same edge frees a slot.
  assign con_accept = con_push && (!con_full || con_pop);

  assign unused_addr_bits = ^{bus.DADDR[27:AW], bus.IADDR[29:AW]};

  assign bus.INSTR        = bus.IREQ ? mem[bus.IADDR[AW-1:0]] : 32'h0;
  assign bus.DRDATA       = drdata_q;
  assign bus.TOHOST_VALID = tohost_valid_q;
  assign bus.TOHOST_DATA  = tohost_data_q;
  assign bus.CON_VALID    = con_cnt_q != '0;
  assign bus.CON_DATA     = (con_cnt_q != '0) ? con_mem[con_rptr_q] : 8'h0;

  always_comb begin
    rd_word = mem[d_idx];
    if (is_mmio) begin
      unique case (bus.DADDR[1:0])
        2'd0:    rd_word = cycle_q;
        2'd1:    rd_word = tohost_data_q;
        2'd2:    rd_word = {23'b0, ovf_q, 8'(con_cnt_q)};
        default: rd_word = 32'h0;
      endcase
    end
  end

  always_comb begin
    con_wptr_d = con_wptr_q;
    con_rptr_d = con_rptr_q;
    con_cnt_d  = con_cnt_q;
    ovf_d      = ovf_q;
    if (con_pop) begin
      con_rptr_d = con_rptr_q + CON_AW'(1);
      con_cnt_d  = con_cnt_d - CntW'(1);
    end
    if (con_push) begin
      if (!con_accept) begin
        ovf_d = 1'b1;
      end else begin
        con_wptr_d = con_wptr_q + CON_AW'(1);
        con_cnt_d  = con_cnt_d + CntW'(1);
      end
    end
  end

  // RAM is not reset; backdoor load is written last so it wins on an index clash.
  always_ff @(posedge CLK) begin
    if (ram_we) mem[d_idx] <= bus.DWDATA;
    if (bus.LD_EN) mem[bus.LD_ADDR] <= bus.LD_DATA;
  end

  always_ff @(posedge CLK) begin
    if (con_accept) con_mem[con_wptr_q] <= bus.DWDATA[7:0];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      drdata_q       <= '0;
      cycle_q        <= '0;
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= '0;
      ovf_q          <= 1'b0;
      con_wptr_q     <= '0;
      con_rptr_q     <= '0;
      con_cnt_q      <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (rd) drdata_q <= rd_word;
      if (tohost_we) begin
        tohost_valid_q <= 1'b1;
        tohost_data_q  <= bus.DWDATA;
      end
      ovf_q      <= ovf_d;
      con_wptr_q <= con_wptr_d;
      con_rptr_q <= con_rptr_d;
      con_cnt_q  <= con_cnt_d;
    end
  end
endmodule

// File: tb/tb_toy_mem_responder.sv
// Randomized and directed bench for toy_mem_responder against a queue/array reference model.
module tb_toy_mem_responder;
  localparam int unsigned AW    = 10;
  localparam int unsigned Words = 1 << AW;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  toy_mem_responder_if #(.AW(AW)) bus ();

  toy_mem_responder #(.AW(AW), .CON_AW(3)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_mem [Words];
  logic [31:0] ref_cycle, ref_tohost_d, exp_drdata;
  logic        ref_tohost_v, ref_ovf;
  logic [7:0]  ref_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] mmio(input logic [1:0] r);
    return {2'b11, 26'h0, r};
  endfunction

  task automatic idle();
    bus.IREQ = 1'b0; bus.IADDR = '0;
    bus.DREQ = 1'b0; bus.DRW = 2'b00; bus.DADDR = '0; bus.DWDATA = '0;
    bus.LD_EN = 1'b0; bus.LD_ADDR = '0; bus.LD_DATA = '0;
    bus.CON_POP = 1'b0;
  endtask

  // Apply the current inputs to the model, clock once, compare all outputs.
  task automatic tick();
    bit mmio_sel, rd, wr, full, pop_ok;
    logic [AW-1:0] idx;
    #1;
    check("instr", bus.INSTR, bus.IREQ ? ref_mem[bus.IADDR[AW-1:0]] : 32'h0);
    mmio_sel = bus.DADDR[29:28] == 2'b11;
    idx      = bus.DADDR[AW-1:0];
    rd       = bus.DREQ && bus.DRW == 2'b00;
    wr       = bus.DREQ && bus.DRW == 2'b01;
    if (rd) begin
      if (!mmio_sel) exp_drdata = ref_mem[idx];
      else if (bus.DADDR[1:0] == 2'd0) exp_drdata = ref_cycle;
      else if (bus.DADDR[1:0] == 2'd1) exp_drdata = ref_tohost_d;
      else if (bus.DADDR[1:0] == 2'd2) exp_drdata = {23'b0, ref_ovf, 8'(ref_q.size())};
      else exp_drdata = 32'h0;
    end
    if (wr && !mmio_sel) ref_mem[idx] = bus.DWDATA;
    if (bus.LD_EN) ref_mem[bus.LD_ADDR] = bus.LD_DATA;
    if (wr && mmio_sel && bus.DADDR[1:0] == 2'd1) begin
      ref_tohost_v = 1'b1;
      ref_tohost_d = bus.DWDATA;
    end
    full   = ref_q.size() == 8;
    pop_ok = bus.CON_POP && ref_q.size() != 0;
    if (pop_ok) void'(ref_q.pop_front());
    if (wr && mmio_sel && bus.DADDR[1:0] == 2'd2) begin
      if (full && !pop_ok) ref_ovf = 1'b1;
      else ref_q.push_back(bus.DWDATA[7:0]);
    end
    ref_cycle++;
    @(posedge clk);
    #1;
    check("drdata", bus.DRDATA, exp_drdata);
    check("con_valid", 32'(bus.CON_VALID), 32'(ref_q.size() != 0));
    check("con_data", 32'(bus.CON_DATA), (ref_q.size() != 0) ? 32'(ref_q[0]) : 32'h0);
    check("tohost_valid", 32'(bus.TOHOST_VALID), 32'(ref_tohost_v));
    check("tohost_data", bus.TOHOST_DATA, ref_tohost_d);
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    #2;
    check("rst_drdata", bus.DRDATA, 32'h0);
    check("rst_con_valid", 32'(bus.CON_VALID), 32'h0);
    check("rst_con_data", 32'(bus.CON_DATA), 32'h0);
    check("rst_tohost_valid", 32'(bus.TOHOST_VALID), 32'h0);
    check("rst_tohost_data", bus.TOHOST_DATA, 32'h0);
    ref_cycle = '0; exp_drdata = '0; ref_tohost_v = 1'b0; ref_tohost_d = '0; ref_ovf = 1'b0;
    ref_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic dwrite(input logic [29:0] a, input logic [31:0] d);
    idle(); bus.DREQ = 1'b1; bus.DRW = 2'b01; bus.DADDR = a; bus.DWDATA = d;
    tick(); idle();
  endtask

  task automatic dread(input logic [29:0] a);
    idle(); bus.DREQ = 1'b1; bus.DRW = 2'b00; bus.DADDR = a;
    tick(); idle();
  endtask

  task automatic ld(input logic [AW-1:0] a, input logic [31:0] d);
    idle(); bus.LD_EN = 1'b1; bus.LD_ADDR = a; bus.LD_DATA = d;
    tick(); idle();
  endtask

  task automatic rand_inputs();
    bus.IREQ   = 1'($urandom_range(0, 1));
    bus.IADDR  = 30'($urandom);
    bus.DREQ   = $urandom_range(0, 3) != 0;
    bus.DRW    = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 2) == 0)
      bus.DADDR = {2'b11, 26'($urandom), ($urandom_range(0, 1) != 0) ? 2'd2 : 2'($urandom)};
    else
      bus.DADDR = {2'($urandom_range(0, 2)), 18'($urandom), 10'($urandom_range(0, 15))};
    bus.DWDATA  = $urandom;
    bus.LD_EN   = $urandom_range(0, 5) == 0;
    bus.LD_ADDR = AW'($urandom_range(0, 15));
    bus.LD_DATA = $urandom;
    bus.CON_POP = $urandom_range(0, 3) == 0;
  endtask

  initial begin
    logic [31:0] c0;
    idle();
    #1;
    do_reset();

    for (int i = 0; i < int'(Words); i++) ld(AW'(i), $urandom);

    ld(AW'(5), 32'hDEADBEEF);
    bus.IREQ = 1'b1; bus.IADDR = 30'd5;
    #1 check("instr_hit", bus.INSTR, 32'hDEADBEEF);
    bus.IREQ = 1'b0;
    #1 check("instr_idle", bus.INSTR, 32'h0);

    dwrite(30'h10, 32'h12345678);
    dread(30'h10);
    check("ram_rd", bus.DRDATA, 32'h12345678);
    dread(30'h410);
    check("ram_alias", bus.DRDATA, 32'h12345678);

    ld(AW'(7), 32'h1);
    idle(); bus.DREQ = 1'b1; bus.DADDR = 30'd7;
    bus.LD_EN = 1'b1; bus.LD_ADDR = AW'(7); bus.LD_DATA = 32'hAAAA;
    tick(); idle();
    check("same_cycle_old", bus.DRDATA, 32'h1);
    dread(30'd7);
    check("next_cycle_new", bus.DRDATA, 32'hAAAA);

    dread(mmio(2'd0));
    c0 = bus.DRDATA;
    repeat (9) tick();
    dread(mmio(2'd0));
    check("cycle_delta", bus.DRDATA - c0, 32'd10);
    do_reset();
    dread(mmio(2'd0));
    check("cycle_after_rst", bus.DRDATA, 32'h0);

    dwrite(mmio(2'd1), 32'h1);
    check("tohost_v1", 32'(bus.TOHOST_VALID), 32'h1);
    check("tohost_d1", bus.TOHOST_DATA, 32'h1);
    dwrite(mmio(2'd1), 32'h2);
    check("tohost_v2", 32'(bus.TOHOST_VALID), 32'h1);
    check("tohost_d2", bus.TOHOST_DATA, 32'h2);

    for (int i = 0; i < 9; i++) dwrite(mmio(2'd2), 32'h41 + 32'(i));
    dread(mmio(2'd2));
    check("con_status_ovf", bus.DRDATA, 32'h0000_0108);
    for (int i = 0; i < 8; i++) begin
      check("con_pop_order", 32'(bus.CON_DATA), 32'h41 + 32'(i));
      bus.CON_POP = 1'b1;
      tick(); idle();
    end
    check("con_drained", 32'(bus.CON_VALID), 32'h0);
    for (int i = 0; i < 8; i++) dwrite(mmio(2'd2), 32'h61 + 32'(i));
    idle(); bus.DREQ = 1'b1; bus.DRW = 2'b01; bus.DADDR = mmio(2'd2); bus.DWDATA = 32'h5A;
    bus.CON_POP = 1'b1;
    tick(); idle();
    dread(mmio(2'd2));
    check("con_full_pushpop", bus.DRDATA, 32'h0000_0108);
    check("con_head_after", 32'(bus.CON_DATA), 32'h62);

    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      tick();
      if (i == 300) do_reset();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
